wshb_sdram_arbiter: RTL and testbench
=====================================

// Module: wshb_sdram_arbiter
// PURPOSE
//  Shares the single SDRAM Wishbone slave port (wshb_if_sdram side of hw_support) between NB_MASTERS
//  Wishbone masters (master 0 = video stream reader, master 1 = frame writer/test-pattern source).
//  Registered round-robin grant held for the full bus cycle (cyc), combinational request/response
//  routing. Sits in Top between the masters and hw_support.
// PARAMETERS
//  NB_MASTERS   2   number of requesting masters (2..4)
//  DATA_BYTES   4   Wishbone data width in bytes, matches wshb_if
//  ADR_W        32  Wishbone address width
// PORTS
//  sys_clk     in   1    system clock, 100 MHz
//  sys_rst_n   in   1    asynchronous active-low reset
//  wshb_ifs[NB_MASTERS]  slave modport  wshb_if   one per requester; index = fixed master id
//  wshb_ifm    master modport  wshb_if   towards SDRAM slave
//  grant_o     out  NB_MASTERS  one-hot current owner, all-zero when idle (debug/LED)
// BEHAVIOUR
//  Clock/reset: one clock, sys_clk; reset is asynchronous and active-low (sys_rst_n). All flops clear on reset.
//  Reset values: grant_o=0, state=IDLE, rr pointer=0; wshb_ifm.cyc/stb/we=0, adr/dat_ms/sel/cti/bte=0;
//   every wshb_ifs[i].ack/err/rty=0. dat_sm is a broadcast, value don't-care.
//  Request: req[i] = wshb_ifs[i].cyc. stb without cyc is ignored.
//  FSM (package enum arb_state_t): IDLE, BUSY.
//   IDLE: if any req, pick winner = first requester at or after rr pointer (circular);
//     next cycle BUSY, grant_o=onehot(winner). No req -> stay IDLE.
//   BUSY: hold grant while wshb_ifs[owner].cyc=1, regardless of other requests (no preemption).
//     When owner cyc=0 -> IDLE, grant_o=0, rr pointer = owner+1 (mod NB_MASTERS).
//  Latency: request seen in cycle N -> grant in N+1 -> owner's stb reaches slave combinationally in N+1.
//   Release -> re-arbitration costs one IDLE cycle (min gap between owners = 1 cycle).
//  Routing (combinational, from registered grant): wshb_ifm.{cyc,stb,we,adr,dat_ms,sel,cti,bte} = owner's;
//   all forced 0 when IDLE. ack/err/rty from slave go only to owner; non-owners see 0.
//   Non-owners wait with cyc/stb held (standard Wishbone stall).
//  Simultaneous events: owner drops cyc in same cycle another asserts -> IDLE then grant to the
//   requester per rr pointer. All masters request in IDLE -> rr pointer wins.
//  Fairness: with all requesting, owners strictly rotate 0,1,..,NB_MASTERS-1,0.
//  Reset mid-cycle: grant and slave cyc/stb drop asynchronously; slave ack during reset not forwarded.
//  Pipelined/burst (cti=3'b010) transfers pass through unchanged; grant held until cyc drop.
//  Err/rty do not release grant; only cyc drop does.
// STRUCTURE
//  Package wshb_arb_pkg: arb_state_t enum, MAX_MASTERS=4 localparam, function rr_pick(req, ptr).
//  Sub-module rr_picker: combinational rotating-priority encoder (req, ptr -> onehot, valid).
//  Top-level: FSM + pointer flops + generate-based muxes over interface array.
// TESTING
//  1 Reset: sys_rst_n=0 with master0 cyc=1 -> wshb_ifm.cyc=0, grant_o=0, all acks 0.
//  2 Single master: m0 cyc/stb at N, slave ack at N+2 -> grant_o=2'b01 at N+1, m0 ack at N+2, m1 ack 0.
//  3 Contention: m0,m1 request same cycle from reset -> m0 served first; m0 drops cyc -> 1 idle
//    cycle -> grant_o=2'b10; repeat -> order 0,1,0,1.
//  4 No preemption: m0 8-beat burst (cti=010, last 111), m1 requests at beat 2 -> m1 granted only
//    one cycle after m0 cyc=0; exactly 8 acks to m0, none to m1 meanwhile.
//  5 Mid-transfer reset: assert sys_rst_n=0 during m1 ownership -> grant_o=0 same cycle; after
//    release, m0 (ptr=0) wins if both request.
//  6 Err path: slave err on m1 access -> m1 err=1, m0 err=0, grant kept until m1 cyc drops.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared definitions for the SDRAM Wishbone arbiter.
//   arb_state_t  : arbiter FSM states (IDLE / BUSY)
//   MAX_MASTERS  : largest supported number of requesting masters
//   PTR_W        : width of a master index / round-robin pointer
//   rr_pick()    : rotating-priority pick, returns a one-hot of the first
//                  requester found at or after ptr (circular over n masters)
package wshb_arb_pkg;

  localparam int MAX_MASTERS = 4;
  localparam int PTR_W       = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [MAX_MASTERS-1:0] rr_pick(
    input logic [MAX_MASTERS-1:0] req,
    input logic [PTR_W-1:0]       ptr,
    input int                     n
  );
    logic [MAX_MASTERS-1:0] onehot;
    logic                   found;
    logic [PTR_W-1:0]       idx;
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < MAX_MASTERS; k++) begin
      if (k < n) begin
        idx = PTR_W'((int'(ptr) + k) % n);
        if (!found && req[idx]) begin
          onehot[idx] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority encoder.
//   req_i   : request vector, one bit per master
//   ptr_i   : master index with highest priority this round
//   grant_o : one-hot winner (zero when nobody requests)
//   idx_o   : binary index of the winner
//   valid_o : at least one request present
module rr_picker
  import wshb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [MAX_MASTERS-1:0] pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req_i;
  end

  assign pick    = rr_pick(req_ext, ptr_i, N);
  assign grant_o = pick[N-1:0];
  assign valid_o = |pick;

  always_comb begin
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      if (pick[k]) idx_o = PTR_W'(k);
    end
  end

endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM Wishbone slave port between
// NB_MASTERS Wishbone masters. The grant is registered and held for the
// whole bus cycle (until the owner drops cyc); request and response
// routing is combinational from the registered grant.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   s_*_i / s_*_o      : per-master Wishbone slave side, index = master id
//                        (s_dat_o is the read data broadcast to all)
//   m_*_o / m_*_i      : Wishbone master side towards the SDRAM slave
//   grant_o            : one-hot current owner, zero when idle
module wshb_sdram_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int NB_MASTERS = 2,
  parameter int DATA_BYTES = 4,
  parameter int ADR_W      = 32
) (
  input  logic                                     sys_clk,
  input  logic                                     sys_rst_n,
  // requesting masters
  input  logic [NB_MASTERS-1:0]                    s_cyc_i,
  input  logic [NB_MASTERS-1:0]                    s_stb_i,
  input  logic [NB_MASTERS-1:0]                    s_we_i,
  input  logic [NB_MASTERS-1:0][ADR_W-1:0]         s_adr_i,
  input  logic [NB_MASTERS-1:0][DATA_BYTES*8-1:0]  s_dat_i,
  input  logic [NB_MASTERS-1:0][DATA_BYTES-1:0]    s_sel_i,
  input  logic [NB_MASTERS-1:0][2:0]               s_cti_i,
  input  logic [NB_MASTERS-1:0][1:0]               s_bte_i,
  output logic [NB_MASTERS-1:0]                    s_ack_o,
  output logic [NB_MASTERS-1:0]                    s_err_o,
  output logic [NB_MASTERS-1:0]                    s_rty_o,
  output logic [DATA_BYTES*8-1:0]                  s_dat_o,
  // SDRAM slave side
  output logic                                     m_cyc_o,
  output logic                                     m_stb_o,
  output logic                                     m_we_o,
  output logic [ADR_W-1:0]                         m_adr_o,
  output logic [DATA_BYTES*8-1:0]                  m_dat_o,
  output logic [DATA_BYTES-1:0]                    m_sel_o,
  output logic [2:0]                               m_cti_o,
  output logic [1:0]                               m_bte_o,
  input  logic                                     m_ack_i,
  input  logic                                     m_err_i,
  input  logic                                     m_rty_i,
  input  logic [DATA_BYTES*8-1:0]                  m_dat_i,
  // debug
  output logic [NB_MASTERS-1:0]                    grant_o
);

  arb_state_t              state_q, state_d;
  logic [NB_MASTERS-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;

  logic [NB_MASTERS-1:0]   pick_onehot;
  logic [PTR_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic                    owner_cyc;

  rr_picker #(
    .N(NB_MASTERS)
  ) u_picker (
    .req_i  (s_cyc_i),
    .ptr_i  (ptr_q),
    .grant_o(pick_onehot),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  // grant_q is one-hot while BUSY, so this is the owner's cyc
  assign owner_cyc = |(grant_q & s_cyc_i);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          grant_d = pick_onehot;
          owner_d = pick_idx;
        end
      end
      BUSY: begin
        // Only the owner dropping cyc ends ownership; err/rty and other
        // requests have no effect. Pointer moves past the last owner.
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (owner_q == PTR_W'(NB_MASTERS - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Request path: AND-OR mux from the registered grant; everything is
  // zero while idle or in reset. stb is qualified by cyc so a dropped
  // cycle never leaks a strobe.
  always_comb begin
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_adr_o = '0;
    m_dat_o = '0;
    m_sel_o = '0;
    m_cti_o = '0;
    m_bte_o = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (grant_q[i]) begin
        m_cyc_o = s_cyc_i[i];
        m_stb_o = s_cyc_i[i] & s_stb_i[i];
        m_we_o  = s_we_i[i];
        m_adr_o = s_adr_i[i];
        m_dat_o = s_dat_i[i];
        m_sel_o = s_sel_i[i];
        m_cti_o = s_cti_i[i];
        m_bte_o = s_bte_i[i];
      end
    end
  end

  // Response path: terminations reach the owner only.
  for (genvar gi = 0; gi < NB_MASTERS; gi++) begin : g_resp
    assign s_ack_o[gi] = grant_q[gi] & m_ack_i;
    assign s_err_o[gi] = grant_q[gi] & m_err_i;
    assign s_rty_o[gi] = grant_q[gi] & m_rty_i;
  end

  assign s_dat_o = m_dat_i;
  assign grant_o = grant_q;

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
module tb_wshb_sdram_arbiter;

  localparam int N  = 2;
  localparam int DB = 4;
  localparam int AW = 32;
  localparam int DW = DB * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [N-1:0]          s_cyc, s_stb, s_we;
  logic [N-1:0][AW-1:0]  s_adr;
  logic [N-1:0][DW-1:0]  s_dat;
  logic [N-1:0][DB-1:0]  s_sel;
  logic [N-1:0][2:0]     s_cti;
  logic [N-1:0][1:0]     s_bte;
  logic [N-1:0]          s_ack, s_err, s_rty;
  logic [DW-1:0]         s_dat_rd;
  logic                  m_cyc, m_stb, m_we;
  logic [AW-1:0]         m_adr;
  logic [DW-1:0]         m_dat_w;
  logic [DB-1:0]         m_sel;
  logic [2:0]            m_cti;
  logic [1:0]            m_bte;
  logic                  m_ack, m_err, m_rty;
  logic [DW-1:0]         m_dat_r;
  logic [N-1:0]          grant;

  wshb_sdram_arbiter #(.NB_MASTERS(N), .DATA_BYTES(DB), .ADR_W(AW)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_we_i(s_we), .s_adr_i(s_adr),
    .s_dat_i(s_dat), .s_sel_i(s_sel), .s_cti_i(s_cti), .s_bte_i(s_bte),
    .s_ack_o(s_ack), .s_err_o(s_err), .s_rty_o(s_rty), .s_dat_o(s_dat_rd),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_adr_o(m_adr),
    .m_dat_o(m_dat_w), .m_sel_o(m_sel), .m_cti_o(m_cti), .m_bte_o(m_bte),
    .m_ack_i(m_ack), .m_err_i(m_err), .m_rty_i(m_rty), .m_dat_i(m_dat_r),
    .grant_o(grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- slave model ----------------
  int ack_pct = 100, err_pct = 0, rty_pct = 0;
  bit force_ack = 1'b0;

  initial begin
    logic busy;
    int   r;
    m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0; m_dat_r = '0;
    forever begin
      @(posedge clk);
      busy = m_cyc & m_stb & ~m_ack & ~m_err & ~m_rty;
      #1;
      r = $urandom_range(0, 99);
      m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;
      if (force_ack) m_ack = 1'b1;
      else if (busy) begin
        if (r < err_pct) m_err = 1'b1;
        else if (r < err_pct + rty_pct) m_rty = 1'b1;
        else if (r < err_pct + rty_pct + ack_pct) m_ack = 1'b1;
      end
      m_dat_r = $urandom;
    end
  end

  // ---------------- reference model ----------------
  // Owner/pointer bookkeeping straight from the arbitration rules;
  // a transaction record is queued at the moment ownership is expected.
  typedef struct {
    int            id;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic          we;
    logic [DB-1:0] sel;
  } txn_t;

  txn_t exp_q[$];
  bit   sb_en = 1'b0;
  int   mdl_owner = -1;
  int   mdl_ptr   = 0;
  int   nxt_pick;

  function automatic int first_req(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always_comb nxt_pick = first_req(s_cyc, mdl_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_owner <= -1;
      mdl_ptr   <= 0;
    end else if (mdl_owner < 0) begin
      if (nxt_pick >= 0) begin
        mdl_owner <= nxt_pick;
        if (sb_en)
          exp_q.push_back('{nxt_pick, s_adr[nxt_pick], s_dat[nxt_pick],
                            s_we[nxt_pick], s_sel[nxt_pick]});
      end
    end else if (!s_cyc[mdl_owner]) begin
      mdl_ptr   <= (mdl_owner + 1) % N;
      mdl_owner <= -1;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [N-1:0] exp_g;
    logic [N-1:0] id_g;
    logic         exp_cyc;
    txn_t         t;
    forever begin
      @(negedge clk);
      exp_g   = '0;
      exp_cyc = 1'b0;
      if (mdl_owner >= 0) begin
        exp_g[mdl_owner] = 1'b1;
        exp_cyc = s_cyc[mdl_owner];
      end
      chk("grant", grant, exp_g);
      chk("m_cyc", m_cyc, exp_cyc);
      chk("ack_route", s_ack, exp_g & {N{m_ack}});
      chk("err_route", s_err, exp_g & {N{m_err}});
      chk("rty_route", s_rty, exp_g & {N{m_rty}});
      if (sb_en && m_cyc && m_stb && (m_ack || m_err || m_rty)) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 1, 0);
        end else begin
          t = exp_q.pop_front();
          id_g = '0;
          id_g[t.id] = 1'b1;
          $display("txn master=%0d adr=%08h we=%0b ack=%0b err=%0b rty=%0b",
                   t.id, m_adr, m_we, m_ack, m_err, m_rty);
          chk("sb_owner", grant, id_g);
          chk("sb_adr", m_adr, t.adr);
          chk("sb_we", m_we, t.we);
          chk("sb_sel", m_sel, t.sel);
          if (t.we) chk("sb_dat", m_dat_w, t.dat);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic reset_pulse();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drive_req(input int i, input logic [AW-1:0] adr, input logic we, input logic [2:0] cti);
    s_cyc[i] = 1'b1; s_stb[i] = 1'b1; s_adr[i] = adr; s_we[i] = we;
    s_dat[i] = $urandom; s_sel[i] = 4'hF; s_cti[i] = cti; s_bte[i] = 2'b00;
  endtask

  initial begin
    logic [N-1:0] term, g, prev;
    int order[$];
    int zrun, acks0, acks1, idle[N];
    bit done, a0;

    rst_n = 1'b0;
    s_cyc = '0; s_stb = '0; s_we = '0; s_adr = '0; s_dat = '0;
    s_sel = '0; s_cti = '0; s_bte = '0;

    // 1: reset with a pending request and a stuck slave ack
    drive_req(0, 32'hDEAD_0000, 1'b1, 3'b000);
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_cyc", m_cyc, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ack", s_ack, 0);
    chk("rst_m_adr", m_adr, 0);
    tick();
    force_ack = 1'b0; s_cyc = '0; s_stb = '0; rst_n = 1'b1;
    repeat (2) tick();

    // 2: single master
    drive_req(0, 32'h0000_0100, 1'b1, 3'b000);
    @(negedge clk); chk("t2_grant_n", grant, 2'b00);
    tick();
    @(negedge clk);
    chk("t2_grant_n1", grant, 2'b01);
    chk("t2_m_stb", m_stb, 1);
    chk("t2_m_adr", m_adr, 32'h0000_0100);
    tick();
    @(negedge clk); chk("t2_ack", s_ack, 2'b01);
    tick();
    s_cyc[0] = 1'b0; s_stb[0] = 1'b0;
    repeat (3) tick();

    // 3: contention from reset, strict alternation with one idle cycle
    reset_pulse();
    prev = '0; zrun = 0;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      @(negedge clk);
      term = s_ack | s_err | s_rty;
      g = grant;
      if (g != 0 && prev == 0) begin
        order.push_back(g[1] ? 1 : 0);
        if (order.size() > 1) chk("t3_gap", zrun, 1);
      end
      zrun = (g == 0) ? zrun + 1 : 0;
      prev = g;
      tick();
      for (int i = 0; i < N; i++) begin
        if (term[i]) begin
          s_cyc[i] = 1'b0; s_stb[i] = 1'b0;
        end else if (!s_cyc[i]) begin
          drive_req(i, 32'h0000_2000 + 32'(i), 1'b0, 3'b000);
        end
      end
    end
    chk("t3_count", order.size(), 4);
    foreach (order[k]) chk("t3_order", order[k], k % 2);
    s_cyc = '0; s_stb = '0;
    repeat (3) tick();

    // 4: no preemption during an 8-beat burst
    reset_pulse();
    drive_req(0, 32'h0000_1000, 1'b0, 3'b010);
    acks0 = 0; acks1 = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      a0 = s_ack[0];
      if (s_ack[0]) acks0++;
      if (s_ack[1]) acks1++;
      if (c > 0) chk("t4_hold", grant, 2'b01);
      tick();
      if (a0) begin
        s_adr[0] = s_adr[0] + 32'd4;
        if (acks0 == 2) drive_req(1, 32'h0000_3000, 1'b0, 3'b000);
        if (acks0 == 7) s_cti[0] = 3'b111;
        if (acks0 == 8) begin
          s_cyc[0] = 1'b0; s_stb[0] = 1'b0; done = 1'b1;
        end
      end
    end
    chk("t4_acks0", acks0, 8);
    chk("t4_acks1", acks1, 0);
    @(negedge clk); chk("t4_rel_busy", grant, 2'b01);
    tick();
    @(negedge clk); chk("t4_gap", grant, 2'b00);
    tick();
    @(negedge clk); chk("t4_m1", grant, 2'b10);
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      done = s_ack[1];
      tick();
    end
    chk("t4_m1_ack", done, 1);
    s_cyc = '0; s_stb = '0;
    repeat (3) tick();

    // 6: error response goes to the owner only and does not release grant
    reset_pulse();
    ack_pct = 0; err_pct = 100;
    drive_req(1, 32'h0000_4000, 1'b1, 3'b000);
    @(negedge clk);
    tick();
    @(negedge clk); chk("t6_grant", grant, 2'b10);
    tick();
    @(negedge clk);
    chk("t6_err", s_err, 2'b10);
    chk("t6_noack", s_ack, 2'b00);
    tick();
    s_stb[1] = 1'b0;
    drive_req(0, 32'h0000_5000, 1'b0, 3'b000);
    repeat (3) begin
      @(negedge clk);
      chk("t6_hold", grant, 2'b10);
      tick();
    end
    s_cyc[1] = 1'b0;
    @(negedge clk); chk("t6_still", grant, 2'b10);
    tick();
    @(negedge clk); chk("t6_idle", grant, 2'b00);
    tick();
    @(negedge clk); chk("t6_next", grant, 2'b01);
    tick();
    s_cyc = '0; s_stb = '0;
    ack_pct = 100; err_pct = 0;
    repeat (3) tick();

    // 5: reset during master 1 ownership
    reset_pulse();
    ack_pct = 0;
    drive_req(1, 32'h0000_6000, 1'b0, 3'b000);
    @(negedge clk);
    tick();
    @(negedge clk); chk("t5_grant_m1", grant, 2'b10);
    tick();
    rst_n = 1'b0;
    force_ack = 1'b1;
    drive_req(0, 32'h0000_7000, 1'b0, 3'b000);
    #1;
    chk("t5_grant_async", grant, 2'b00);
    chk("t5_cyc_async", m_cyc, 0);
    @(negedge clk); chk("t5_ack_in_rst", s_ack, 2'b00);
    tick();
    force_ack = 1'b0;
    rst_n = 1'b1;
    g = '0;
    for (int c = 0; c < 6 && g == 0; c++) begin
      @(negedge clk);
      g = grant;
    end
    chk("t5_winner", g, 2'b01);
    tick();
    s_cyc = '0; s_stb = '0;
    ack_pct = 100;
    repeat (3) tick();

    // random traffic against the scoreboard
    reset_pulse();
    ack_pct = 60; err_pct = 10; rty_pct = 5;
    sb_en = 1'b1;
    foreach (idle[i]) idle[i] = $urandom_range(0, 3);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      term = s_ack | s_err | s_rty;
      tick();
      for (int i = 0; i < N; i++) begin
        if (s_cyc[i]) begin
          if (term[i]) begin
            s_cyc[i] = 1'b0; s_stb[i] = 1'b0;
            idle[i] = $urandom_range(1, 4);
          end
        end else if (idle[i] > 0) begin
          idle[i]--;
        end else if (c < 2800 && $urandom_range(0, 1) == 1) begin
          s_cyc[i] = 1'b1; s_stb[i] = 1'b1;
          s_adr[i] = $urandom; s_dat[i] = $urandom;
          s_we[i]  = 1'($urandom_range(0, 1));
          s_sel[i] = 4'($urandom_range(0, 15));
          s_cti[i] = 3'b000;
          s_bte[i] = 2'($urandom_range(0, 3));
        end
      end
    end
    chk("rand_idle", s_cyc, '0);
    chk("sb_drain", exp_q.size(), 0);
    sb_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
